// File: rtl/draw_board_cells.sv
// GRID x GRID board overlay for the VGA chain: paints X/O/highlight cells over rgb_in with a
// double-buffered cell board swapped at frame start. Optional cursor ring: define BOARD_CURSOR_EN.
module draw_board_cells #(
  parameter int          GRID         = 3,
  parameter int          H_ORG        = 0,
  parameter int          V_ORG        = 0,
  parameter int          CELL_W       = 341,
  parameter int          CELL_H       = 256,
  parameter int          INSET        = 8,
  parameter logic [11:0] COLOR_X      = 12'hf_0_0,
  parameter logic [11:0] COLOR_O      = 12'h0_0_f,
  parameter logic [11:0] COLOR_HL     = 12'hf_f_0,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic                   pclk,
  input  logic                   rst,
  input  logic [10:0]            hcount_in,
  input  logic [10:0]            vcount_in,
  input  logic                   hsync_in,
  input  logic                   hblnk_in,
  input  logic                   vsync_in,
  input  logic                   vblnk_in,
  input  logic [11:0]            rgb_in,
  input  logic                   start_en,
  input  logic                   cell_wr,
  input  logic [3:0]             cell_idx,
  input  logic [1:0]             cell_val,
  input  logic                   clear,
  input  logic [GRID*GRID-1:0]   hl_mask,
`ifdef BOARD_CURSOR_EN
  input  logic [3:0]             cursor_idx,
  input  logic                   cursor_on,
`endif
  output logic [10:0]            hcount_out,
  output logic [10:0]            vcount_out,
  output logic                   hsync_out,
  output logic                   hblnk_out,
  output logic                   vsync_out,
  output logic                   vblnk_out,
  output logic [11:0]            rgb_out
);

  localparam int NCELL = GRID * GRID;
  localparam int CW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Board storage: 2 bits per cell, cell i at [2*i +: 2]
  logic [2*NCELL-1:0] shadow_q, shadow_d, active_q;
  logic [NCELL-1:0]   mask_q;
  logic               vblnk_prev_q;
  logic               frame_edge;
  logic [CW-1:0]      frame_cnt_q;
  logic               blink_q;

  // Stage 1
  logic [10:0] hcount1_q, vcount1_q;
  logic        hsync1_q, hblnk1_q, vsync1_q, vblnk1_q;
  logic [11:0] rgb1_q;
  logic        start1_q, in_board1_q, in_inset1_q;
  logic [1:0]  row1_q, col1_q;
  logic [3:0]  cell1_q;

  logic [1:0]  row_d, col_d;
  logic        in_col, in_row, in_board_d, in_inset_d;
  logic [3:0]  cell_d;
  int          hx, vx, ox, oy;

  // Stage 2
  logic [1:0]  cur_val;
  logic        cur_hl;
  logic [11:0] rgb_d;

  assign frame_edge = vblnk_in & ~vblnk_prev_q;

  always_comb begin
    shadow_d = shadow_q;
    if (clear) begin
      shadow_d = '0;
    end else if (cell_wr) begin
      for (int i = 0; i < NCELL; i++) begin
        if (int'(cell_idx) == i) shadow_d[2*i +: 2] = cell_val;
      end
    end
  end

  // Locate the pixel by range compares against each cell's constant bounds
  always_comb begin
    hx     = int'(hcount_in);
    vx     = int'(vcount_in);
    col_d  = '0;
    row_d  = '0;
    in_col = 1'b0;
    in_row = 1'b0;
    ox     = 0;
    oy     = 0;
    for (int i = 0; i < GRID; i++) begin
      if (hx >= H_ORG + i * CELL_W && hx <= H_ORG + (i + 1) * CELL_W - 1) begin
        in_col = 1'b1;
        col_d  = 2'(i);
        ox     = hx - (H_ORG + i * CELL_W);
      end
      if (vx >= V_ORG + i * CELL_H && vx <= V_ORG + (i + 1) * CELL_H - 1) begin
        in_row = 1'b1;
        row_d  = 2'(i);
        oy     = vx - (V_ORG + i * CELL_H);
      end
    end
    in_board_d = in_col & in_row;
    in_inset_d = (ox >= INSET) && (ox <= CELL_W - 1 - INSET) &&
                 (oy >= INSET) && (oy <= CELL_H - 1 - INSET);
    cell_d     = 4'(int'(row_d) * GRID + int'(col_d));
  end

`ifdef BOARD_CURSOR_EN
  logic ring_d, ring1_q, cur_on1_q;
  int   dist;

  always_comb begin
    dist = ox;
    if (CELL_W - 1 - ox < dist) dist = CELL_W - 1 - ox;
    if (oy < dist) dist = oy;
    if (CELL_H - 1 - oy < dist) dist = CELL_H - 1 - oy;
    ring_d = in_board_d && !in_inset_d && (dist >= INSET - 4) && (cursor_idx == cell_d);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      ring1_q   <= 1'b0;
      cur_on1_q <= 1'b0;
    end else begin
      ring1_q   <= ring_d;
      cur_on1_q <= cursor_on;
    end
  end
`endif

  always_ff @(posedge pclk) begin
    if (rst) begin
      shadow_q     <= '0;
      active_q     <= '0;
      mask_q       <= '0;
      vblnk_prev_q <= 1'b0;
      frame_cnt_q  <= '0;
      blink_q      <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      vblnk_prev_q <= vblnk_in;
      if (frame_edge) begin
        active_q <= shadow_d;
        mask_q   <= hl_mask;
        if (frame_cnt_q == CW'(BLINK_FRAMES - 1)) begin
          frame_cnt_q <= '0;
          blink_q     <= ~blink_q;
        end else begin
          frame_cnt_q <= frame_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount1_q   <= '0;
      vcount1_q   <= '0;
      hsync1_q    <= 1'b0;
      hblnk1_q    <= 1'b0;
      vsync1_q    <= 1'b0;
      vblnk1_q    <= 1'b0;
      rgb1_q      <= '0;
      start1_q    <= 1'b0;
      in_board1_q <= 1'b0;
      in_inset1_q <= 1'b0;
      row1_q      <= '0;
      col1_q      <= '0;
      cell1_q     <= '0;
    end else begin
      hcount1_q   <= hcount_in;
      vcount1_q   <= vcount_in;
      hsync1_q    <= hsync_in;
      hblnk1_q    <= hblnk_in;
      vsync1_q    <= vsync_in;
      vblnk1_q    <= vblnk_in;
      rgb1_q      <= rgb_in;
      start1_q    <= start_en;
      in_board1_q <= in_board_d;
      in_inset1_q <= in_inset_d;
      row1_q      <= row_d;
      col1_q      <= col_d;
      cell1_q     <= cell_d;
    end
  end

  always_comb begin
    cur_val = '0;
    cur_hl  = 1'b0;
    for (int i = 0; i < NCELL; i++) begin
      if (int'(cell1_q) == i) begin
        cur_val = active_q[2*i +: 2];
        cur_hl  = mask_q[i];
      end
    end
  end

  always_comb begin
    rgb_d = rgb1_q;
    if (!hblnk1_q && !vblnk1_q) begin
      if (start1_q && in_board1_q && in_inset1_q) begin
        if (cur_hl && blink_q)    rgb_d = COLOR_HL;
        else if (cur_val == 2'd1) rgb_d = COLOR_X;
        else if (cur_val == 2'd2) rgb_d = COLOR_O;
      end
`ifdef BOARD_CURSOR_EN
      if (ring1_q && cur_on1_q) rgb_d = 12'hf_f_f;
`endif
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= hcount1_q;
      vcount_out <= vcount1_q;
      hsync_out  <= hsync1_q;
      hblnk_out  <= hblnk1_q;
      vsync_out  <= vsync1_q;
      vblnk_out  <= vblnk1_q;
      rgb_out    <= rgb_d;
    end
  end

  // row/col are kept alongside the flat cell index for debug visibility
  logic unused_rc;
  assign unused_rc = ^{row1_q, col1_q};

endmodule

// File: tb/tb_draw_board_cells.sv
// Randomised self-checking bench for draw_board_cells against a behavioural board model,
// plus directed literal checks of reset, latency, swap, blink, clear and pass-through.
module tb_draw_board_cells;

  localparam int          GRID   = 3;
  localparam int          H_ORG  = 0;
  localparam int          V_ORG  = 0;
  localparam int          CELL_W = 341;
  localparam int          CELL_H = 256;
  localparam int          INSET  = 8;
  localparam logic [11:0] C_X    = 12'hf_0_0;
  localparam logic [11:0] C_O    = 12'h0_0_f;
  localparam logic [11:0] C_HL   = 12'hf_f_0;
  localparam int          BF     = 2;
  localparam int          NCELL  = GRID * GRID;

  logic        pclk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
  logic [11:0] rgb_in;
  logic        start_en, cell_wr, clear;
  logic [3:0]  cell_idx;
  logic [1:0]  cell_val;
  logic [NCELL-1:0] hl_mask;
  logic [3:0]  cursor_idx;
  logic        cursor_on;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] rgb_out;

  int checks = 0;
  int errors = 0;

  draw_board_cells #(
    .GRID(GRID), .H_ORG(H_ORG), .V_ORG(V_ORG), .CELL_W(CELL_W), .CELL_H(CELL_H),
    .INSET(INSET), .COLOR_X(C_X), .COLOR_O(C_O), .COLOR_HL(C_HL), .BLINK_FRAMES(BF)
  ) dut (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .hblnk_in(hblnk_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .start_en(start_en), .cell_wr(cell_wr), .cell_idx(cell_idx),
    .cell_val(cell_val), .clear(clear), .hl_mask(hl_mask),
`ifdef BOARD_CURSOR_EN
    .cursor_idx(cursor_idx), .cursor_on(cursor_on),
`endif
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .hblnk_out(hblnk_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  always #5 pclk = ~pclk;

  // Behavioural model state
  int sh[NCELL];
  int act[NCELL];
  bit mk[NCELL];
  int nb;
  bit pv;

  function automatic logic [11:0] model_rgb(int h, int v, bit hb, bit vb, logic [11:0] rgb,
                                            bit st, int cidx, bit con);
    int c, r, ox, oy, idx, d;
    bit ins;
    if (hb || vb) return rgb;
    if (h < H_ORG || h >= H_ORG + GRID * CELL_W) return rgb;
    if (v < V_ORG || v >= V_ORG + GRID * CELL_H) return rgb;
    c   = (h - H_ORG) / CELL_W;
    r   = (v - V_ORG) / CELL_H;
    ox  = (h - H_ORG) % CELL_W;
    oy  = (v - V_ORG) % CELL_H;
    idx = r * GRID + c;
    ins = ox >= INSET && ox < CELL_W - INSET && oy >= INSET && oy < CELL_H - INSET;
    d = ox;
    if (CELL_W - 1 - ox < d) d = CELL_W - 1 - ox;
    if (oy < d) d = oy;
    if (CELL_H - 1 - oy < d) d = CELL_H - 1 - oy;
`ifdef BOARD_CURSOR_EN
    if (con && cidx == idx && !ins && d >= INSET - 4) return 12'hf_f_f;
`else
    if (con && cidx < 0 && d < 0) return rgb;
`endif
    if (!st || !ins) return rgb;
    if (mk[idx] && ((nb / BF) % 2 == 1)) return C_HL;
    if (act[idx] == 1) return C_X;
    if (act[idx] == 2) return C_O;
    return rgb;
  endfunction

  // Compare process: advance the model on each edge, check outputs 1 time unit later
  initial begin
    logic [37:0] pend, out_exp;
    bit armed;
    int ci;
    armed = 0;
    pend  = '0;
    forever begin
      @(posedge pclk);
      if (rst) begin
        foreach (sh[i]) begin sh[i] = 0; act[i] = 0; mk[i] = 0; end
        nb = 0; pv = 0; pend = '0; out_exp = '0; armed = 1;
      end else begin
        out_exp = pend;
        if (clear) begin
          foreach (sh[i]) sh[i] = 0;
        end else if (cell_wr && int'(cell_idx) < NCELL) begin
          sh[int'(cell_idx)] = int'(cell_val);
        end
        if (vblnk_in && !pv) begin
          foreach (sh[i]) begin act[i] = sh[i]; mk[i] = hl_mask[i]; end
          nb++;
        end
        pv = vblnk_in;
`ifdef BOARD_CURSOR_EN
        ci = int'(cursor_idx);
`else
        ci = 0;
`endif
        pend = {hcount_in, vcount_in, hsync_in, hblnk_in, vsync_in, vblnk_in,
                model_rgb(int'(hcount_in), int'(vcount_in), hblnk_in, vblnk_in, rgb_in,
                          start_en, ci, cursor_on)};
      end
      #1;
      if (armed) begin
        checks++;
        if ({hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out} !==
            out_exp[37:12]) begin
          errors++;
          $display("FAIL timing t=%0t: got %h expected %h", $time,
                   {hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out},
                   out_exp[37:12]);
        end
        checks++;
        if (rgb_out !== out_exp[11:0]) begin
          errors++;
          $display("FAIL rgb t=%0t: got %h expected %h", $time, rgb_out, out_exp[11:0]);
        end
      end
    end
  end

  task automatic set_idle();
    rst = 0; hcount_in = 11'd1100; vcount_in = 11'd10; hsync_in = 0; hblnk_in = 0;
    vsync_in = 0; vblnk_in = 0; rgb_in = 12'($urandom); cell_wr = 0; clear = 0;
    cell_idx = 0; cell_val = 0;
  endtask

  task automatic lit(string name, logic [37:0] got, logic [37:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic write(int idx, int val);
    @(negedge pclk); set_idle(); cell_wr = 1; cell_idx = 4'(idx); cell_val = 2'(val);
  endtask

  task automatic boundary();
    @(negedge pclk); set_idle(); vblnk_in = 1;
    @(negedge pclk); set_idle(); vblnk_in = 1;
    @(negedge pclk); set_idle();
  endtask

  task automatic check_pix(string name, int h, int v, logic [11:0] rgb, logic [11:0] want);
    @(negedge pclk); set_idle(); hcount_in = 11'(h); vcount_in = 11'(v); rgb_in = rgb;
    @(negedge pclk); set_idle();
    @(posedge pclk); #1;
    lit(name, {26'd0, rgb_out}, {26'd0, want});
  endtask

  logic [11:0] blink_exp [6];

  initial begin
    set_idle();
    rst = 1; hsync_in = 1; vsync_in = 1; rgb_in = 12'hfff; hcount_in = 11'd500;
    start_en = 1; hl_mask = '0; cursor_idx = 0; cursor_on = 0;
    repeat (3) @(posedge pclk);
    #1;
    lit("reset_outputs", {hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out,
                          rgb_out}, 38'd0);

    // 2-cycle latency on hsync
    @(negedge pclk); set_idle(); hsync_in = 1;
    @(posedge pclk); #1; lit("hsync_n1", {37'd0, hsync_out}, 38'd0);
    @(negedge pclk); set_idle();
    @(posedge pclk); #1; lit("hsync_n2", {37'd0, hsync_out}, 38'd1);
    @(negedge pclk); set_idle();
    @(posedge pclk); #1; lit("hsync_n3", {37'd0, hsync_out}, 38'd0);

    // Shadow write stays hidden until the frame swap
    write(4, 1);
    check_pix("pre_swap", 512, 384, 12'h123, 12'h123);
    boundary();
    check_pix("post_swap_x", 512, 384, 12'h456, C_X);
    check_pix("inset_band", 345, 260, 12'h789, 12'h789);

    write(0, 2);
    write(9, 1);
    boundary();
    check_pix("cell0_o", 100, 100, 12'h321, C_O);
    check_pix("cell4_kept", 512, 384, 12'h654, C_X);
    check_pix("cell8_empty", 1000, 700, 12'h0a5, 12'h0a5);

    // Clear beats a simultaneous write
    @(negedge pclk); set_idle(); clear = 1; cell_wr = 1; cell_idx = 4'd2; cell_val = 2'd1;
    boundary();
    check_pix("clear_c2", 800, 100, 12'h111, 12'h111);
    check_pix("clear_c4", 512, 384, 12'h222, 12'h222);
    write(0, 1);
    boundary();
    start_en = 0;
    check_pix("start_off", 100, 100, 12'h333, 12'h333);
    start_en = 1;
    check_pix("start_on", 100, 100, 12'h444, C_X);

    // Blink: restart counters, phase alternates every BF frames
    @(negedge pclk); set_idle(); rst = 1;
    @(negedge pclk); set_idle();
    hl_mask = 9'b000000001;
    write(0, 1);
    repeat (4) boundary();
    blink_exp = '{C_X, C_X, C_HL, C_HL, C_X, C_X};
    for (int f = 0; f < 6; f++) begin
      check_pix($sformatf("blink_f%0d", f), 100, 100, 12'h5a5, blink_exp[f]);
      boundary();
    end
    hl_mask = '0;

`ifdef BOARD_CURSOR_EN
    cursor_idx = 4'd8; cursor_on = 1;
    check_pix("cursor_on", 1018, 762, 12'h246, 12'hfff);
    cursor_on = 0;
    check_pix("cursor_off", 1018, 762, 12'h246, 12'h246);
`endif

    // Randomised frames checked by the model every cycle
    for (int f = 0; f < 40; f++) begin
      int len;
      len = $urandom_range(200, 500);
      for (int k = 0; k < len; k++) begin
        @(negedge pclk);
        rst       = ($urandom % 2000 == 0);
        hcount_in = 11'($urandom_range(0, 1100));
        vcount_in = 11'($urandom_range(0, 800));
        hsync_in  = 1'($urandom);
        vsync_in  = 1'($urandom);
        hblnk_in  = ($urandom % 10 == 0);
        vblnk_in  = 0;
        rgb_in    = 12'($urandom);
        cell_wr   = ($urandom % 5 == 0);
        cell_idx  = 4'($urandom);
        cell_val  = 2'($urandom);
        clear     = ($urandom % 100 == 0);
        if ($urandom % 50 == 0) hl_mask = NCELL'($urandom);
        if ($urandom % 300 == 0) start_en = ~start_en;
        if ($urandom % 40 == 0) begin
          cursor_idx = 4'($urandom_range(0, 9));
          cursor_on  = 1'($urandom);
        end
      end
      for (int k = 0; k < int'($urandom_range(2, 6)); k++) begin
        @(negedge pclk);
        rst = 0; vblnk_in = 1; hcount_in = 11'($urandom_range(0, 1100));
        rgb_in = 12'($urandom); cell_wr = ($urandom % 3 == 0); cell_idx = 4'($urandom);
        cell_val = 2'($urandom); clear = 0;
      end
    end

    @(negedge pclk); set_idle();
    repeat (3) @(posedge pclk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
